sram_arbiter: RTL
=================

Name: sram_arbiter

Overview:
- Two-port round-robin arbiter that shares one single-port synchronous SRAM between requester 0 (microcode loader) and requester 1 (instruction fetch).
- Each cycle it grants at most one request and drives the SRAM control, address and data lines from the winner.
- It routes the registered read data back to the requester that issued the read, with a read-valid strobe.
- Optional lock lets one requester own the SRAM for a bounded burst.

Parameters:
- N, 8, data width in bits.
- ADDR_W, 6, SRAM address width in bits.
- LOCK_MAX, 4, maximum consecutive locked grants while the other port is requesting (must be >=1).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- p0_req  in  1  port-0 request.
- p0_we  in  1  port-0 write (1) / read (0).
- p0_lock  in  1  port-0 keep-ownership hint.
- p0_addr  in  ADDR_W  port-0 address.
- p0_wdata  in  N  port-0 write data.
- p0_gnt  out  1  port-0 request accepted this cycle.
- p0_rvalid  out  1  port-0 read data valid.
- p1_req, p1_we, p1_lock, p1_addr, p1_wdata, p1_gnt, p1_rvalid: same as port 0, for port 1.
- rdata  out  N  read data, shared by both ports; qualify with pX_rvalid.
- sram_re  out  1  SRAM read enable.
- sram_we  out  1  SRAM write enable.
- sram_addr  out  ADDR_W  SRAM address.
- sram_wdata  out  N  SRAM write data.
- sram_rdata  in  N  SRAM registered read data.

Behaviour:
- Handshake: a request is held stable until pX_gnt=1 in the same cycle. pX_gnt is combinational from req, state and priority. One transfer per grant; back-to-back grants every cycle are allowed.
- SRAM drive:
  - On grant: sram_we=winner.we, sram_re=!winner.we, sram_addr/sram_wdata=winner fields.
  - No grant: sram_re=sram_we=0, addr/wdata=0.
  - Never both enables high.
- Read latency: read granted in cycle T -> pX_rvalid=1 in T+1 for that port only, rdata=sram_rdata in T+1. Writes produce no rvalid.
  - A 1-bit valid plus 1-bit owner-tag register implements the return path.
  - rdata passes through combinationally.
- Priority pointer rr:
  - Reset rr=0 (port 0 preferred).
  - After any unlocked grant, rr points to the non-winning port.
  - If only one port requests, it wins regardless of rr.
- FSM states:
  - IDLE: no owner. Arbitrate with rr. If the winner has lock=1, go to OWN0/OWN1 and set burst count = 1.
  - OWNx: port x wins whenever it requests, even if the other port requests.
    - Each grant increments the burst count.
    - Return to IDLE when x deasserts lock, or x deasserts req, or the burst count reaches LOCK_MAX while the other port requests. In that case rr points to the other port.
    - The count saturates at LOCK_MAX when the other port is idle; ownership continues.
  - The transition out of OWNx takes effect the following cycle. The cycle that hits LOCK_MAX is still granted to x.
- Simultaneous events:
  - Both ports request in IDLE -> the rr port wins. The loser waits and is guaranteed the next grant unless the winner holds lock.
  - Worst-case wait is LOCK_MAX+1 cycles.
- Reset values (async, rst_n low): state=IDLE, rr=0, burst count=0, rvalid tag cleared. Therefore all pX_gnt, pX_rvalid, sram_re and sram_we are 0.
- Reset mid-operation: any pending read return is dropped (no rvalid after reset release). Lock ownership is lost.
- Wrap-around: addresses pass through unchanged; there is no address arithmetic. The burst counter width is clog2(LOCK_MAX+1).

Decomposition:
- Shared package sram_arb_pkg:
  - arb_state_t enum {IDLE, OWN0, OWN1}.
  - port_id_t (1 bit).
  - Request struct typedef {we, lock, addr, wdata} parameterized through package constants N_DEF=8, ADDR_W_DEF=6.
- One natural sub-module: rr_pick2 (combinational 2-way round-robin picker: req[1:0], rr -> gnt[1:0]).
- FSM, counter and return-path registers stay in sram_arbiter.

Test Plan:
- Reset, then p0 write addr 5 data 8'hA5; next cycle p0 read addr 5 -> p0_gnt=1 both cycles; p0_rvalid=1 one cycle after the read with rdata=8'hA5; p1_rvalid stays 0.
- Both ports read every cycle, no lock, from reset -> grants alternate p0,p1,p0,p1; each rvalid asserts exactly one cycle after its own grant.
- p0 holds req+lock for 10 cycles while p1 requests, LOCK_MAX=4 -> p0 granted 4 cycles, p1 granted cycle 5, p0 resumes afterward; p1 never waits >5 cycles.
- p0 lock burst with p1 idle for 8 cycles -> p0 granted all 8; p1 requests in cycle 9 -> p1 granted within LOCK_MAX+1 cycles.
- p1 read granted, rst_n pulled low before the next clock edge -> no p1_rvalid after release; sram_re=sram_we=0 while in reset; first post-reset contention is won by p0.
- Every granted cycle asserts exactly one of sram_re/sram_we and exactly one pX_gnt; idle cycles assert none.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types for the two-port SRAM arbiter: FSM states, port ids and the request bundle.
package sram_arb_pkg;

  localparam int N_DEF      = 8;
  localparam int ADDR_W_DEF = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  typedef logic port_id_t;

  typedef struct packed {
    logic                  we;
    logic                  lock;
    logic [ADDR_W_DEF-1:0] addr;
    logic [N_DEF-1:0]      wdata;
  } arb_req_t;

  // Ownership state that a locked winner moves into.
  function automatic arb_state_t own_state(input port_id_t p);
    return p ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker; a lone requester always wins.
module rr_pick2
  import sram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  port_id_t   rr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt    = 2'b00;
    gnt[0] = req[0] && (!req[1] || !rr);
    gnt[1] = req[1] && (!req[0] ||  rr);
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one single-port synchronous SRAM between two requesters with round-robin
// priority, bounded lock bursts and a tagged one-cycle read return path.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int LOCK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic              p0_lock,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [N-1:0]      p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic              p1_lock,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [N-1:0]      p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [N-1:0]      rdata,
  output logic              sram_re,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [N-1:0]      sram_wdata,
  input  logic [N-1:0]      sram_rdata
);

  localparam int            CW      = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_MAX);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  arb_state_t    state, state_n;
  port_id_t      rr, rr_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic          rv_valid;
  port_id_t      rv_tag;

  logic [1:0]    pick;
  logic [1:0]    gnt;
  logic          any_gnt;
  port_id_t      win;
  logic          win_we, win_lock, win_other_req;
  port_id_t      owner;
  logic          own_req, own_lock, other_req;

  rr_pick2 u_pick (
    .req ({p1_req, p0_req}),
    .rr  (rr),
    .gnt (pick)
  );

  // Grants are suppressed while reset is asserted so nothing reaches the SRAM.
  always_comb begin
    gnt = 2'b00;
    if (rst_n) begin
      case (state)
        IDLE:    gnt = pick;
        OWN0:    gnt[0] = p0_req;
        OWN1:    gnt[1] = p1_req;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_comb begin
    any_gnt       = |gnt;
    win           = gnt[1];
    win_we        = win ? p1_we   : p0_we;
    win_lock      = win ? p1_lock : p0_lock;
    win_other_req = win ? p0_req  : p1_req;

    sram_re    = any_gnt && !win_we;
    sram_we    = any_gnt &&  win_we;
    sram_addr  = '0;
    sram_wdata = '0;
    if (any_gnt) begin
      sram_addr  = win ? p1_addr  : p0_addr;
      sram_wdata = win ? p1_wdata : p0_wdata;
    end
  end

  always_comb begin
    owner     = (state == OWN1);
    own_req   = owner ? p1_req  : p0_req;
    own_lock  = owner ? p1_lock : p0_lock;
    other_req = owner ? p0_req  : p1_req;
    cnt_inc   = (cnt >= CNT_MAX) ? CNT_MAX : cnt + CNT_ONE;

    state_n = state;
    rr_n    = rr;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (any_gnt) begin
          rr_n = ~win;
          // A one-grant budget is already spent by this grant if the other side waits.
          if (win_lock && !(CNT_MAX == CNT_ONE && win_other_req)) begin
            state_n = own_state(win);
            cnt_n   = CNT_ONE;
          end
        end
      end
      OWN0, OWN1: begin
        if (!own_req || !own_lock || (cnt_inc == CNT_MAX && other_req)) begin
          state_n = IDLE;
          cnt_n   = '0;
          rr_n    = ~owner;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr       <= 1'b0;
      cnt      <= '0;
      rv_valid <= 1'b0;
      rv_tag   <= 1'b0;
    end else begin
      state    <= state_n;
      rr       <= rr_n;
      cnt      <= cnt_n;
      rv_valid <= any_gnt && !win_we;
      rv_tag   <= win;
    end
  end

  always_comb begin
    p0_gnt    = gnt[0];
    p1_gnt    = gnt[1];
    p0_rvalid = rv_valid && !rv_tag;
    p1_rvalid = rv_valid &&  rv_tag;
    rdata     = sram_rdata;
  end

  a_one_enable: assert property (@(posedge clk) disable iff (!rst_n) !(sram_re && sram_we));
  a_one_grant:  assert property (@(posedge clk) disable iff (!rst_n) !(p0_gnt && p1_gnt));

endmodule
